// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode interface: register bit positions and
// receiver state encoding.
package ps2_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;

   // Status register layout
   localparam int unsigned STAT_NOT_EMPTY_BIT  = 31;
   localparam int unsigned STAT_PARITY_ERR_BIT = 30;
   localparam int unsigned STAT_OVERFLOW_BIT   = 29;
   localparam int unsigned STAT_FRAME_ERR_BIT  = 28;
   localparam int unsigned STAT_IRQ_EN_BIT     = 27;
   localparam int unsigned STAT_COUNT_LSB      = 16;
   localparam int unsigned STAT_COUNT_W        = 8;

   // Control register layout
   localparam int unsigned CTRL_FLUSH_BIT      = 31;
   localparam int unsigned CTRL_CLEAR_BIT      = 30;
   localparam int unsigned CTRL_IRQ_EN_BIT     = 29;

   // Scancode read places the head byte here
   localparam int unsigned SCAN_LSB            = 24;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

endpackage

// File: rtl/ps2_scancode_fifo.sv
// Byte FIFO for received scancodes. Flush overrides push/pop; a push while full is
// accepted only when a pop happens in the same cycle.
module ps2_scancode_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [BYTE_W-1:0] wr_data,
   output logic [BYTE_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_en_c, rd_en_c;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_en_c  = push & (~full | pop) & ~flush;
      rd_en_c  = pop & ~empty & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (wr_en_c && !rd_en_c) count_d = count_q + CNT_W'(1);
         else if (!wr_en_c && rd_en_c) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the occupancy count guards every read
   always_ff @(posedge clock) begin
      if (wr_en_c) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/ps2_fifo_interface.sv
// PS/2 keyboard receiver with scancode FIFO and status/control register.
// Optional interrupt enable when PS2_FIFO_IRQ_EN is defined.
module ps2_fifo_interface
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              read,
   input  logic              write,
   input  logic              status_cs,
   input  logic              scancode_cs,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid,
   output logic              irq,
   inout  wire               ps2_clock,
   inout  wire               ps2_data
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]        clk_sync_q, clk_sync_d;
   logic [1:0]        dat_sync_q, dat_sync_d;
   logic              filt_q, filt_d;
   logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
   logic              fall_q, fall_d;

   rx_state_e         state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic              bad_q, bad_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              push_c, set_perr_c, set_ferr_c;

   logic              perr_q, perr_d;
   logic              ovf_q, ovf_d;
   logic              ferr_q, ferr_d;
   logic              ctrl_wr_c, clr_c, flush_c, pop_c;
   logic [DATA_W-1:0] status_c;

   logic [BYTE_W-1:0] fifo_rd_data;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              rx_bit;
   logic              irq_en;

   assign rx_bit = dat_sync_q[1];

   // Synchronise both lines, then debounce the clock line
   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clock};
      dat_sync_d = {dat_sync_q[0], ps2_data};
      filt_d     = filt_q;
      flt_cnt_d  = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
         else flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
      fall_d = filt_q & ~filt_d;
   end

   // Receiver FSM: next state, shift register and timeout
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      bad_d      = bad_q;
      to_cnt_d   = to_cnt_q;
      push_c     = 1'b0;
      set_perr_c = 1'b0;
      set_ferr_c = 1'b0;

      if (state_q == RX_IDLE || fall_q) to_cnt_d = '0;
      else to_cnt_d = to_cnt_q + TO_W'(1);

      if (fall_q) begin
         case (state_q)
            RX_IDLE: begin
               if (!rx_bit) begin
                  state_d   = RX_DATA;
                  bit_cnt_d = '0;
                  bad_d     = 1'b0;
               end
            end
            RX_DATA: begin
               shift_d   = {rx_bit, shift_q[BYTE_W-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
            end
            RX_PARITY: begin
               if ((^{shift_q, rx_bit}) == 1'b0) begin
                  set_perr_c = 1'b1;
                  bad_d      = 1'b1;
               end
               state_d = RX_STOP;
            end
            RX_STOP: begin
               if (!rx_bit) set_ferr_c = 1'b1;
               else if (!bad_q) push_c = 1'b1;
               state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
         endcase
      end else if (state_q != RX_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
         state_d    = RX_IDLE;
         set_ferr_c = 1'b1;
      end
   end

   // Bus decode and sticky flags; a new error beats a same-cycle clear
   always_comb begin
      ctrl_wr_c = write & status_cs;
      clr_c     = ctrl_wr_c & data_in[CTRL_CLEAR_BIT];
      flush_c   = ctrl_wr_c & data_in[CTRL_FLUSH_BIT];
      pop_c     = read & scancode_cs & ~fifo_empty;
      perr_d    = (perr_q & ~clr_c) | set_perr_c;
      ferr_d    = (ferr_q & ~clr_c) | set_ferr_c;
      ovf_d     = (ovf_q & ~clr_c) | (push_c & fifo_full & ~pop_c & ~flush_c);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         flt_cnt_q  <= '0;
         fall_q     <= 1'b0;
         state_q    <= RX_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         bad_q      <= 1'b0;
         to_cnt_q   <= '0;
         perr_q     <= 1'b0;
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         flt_cnt_q  <= flt_cnt_d;
         fall_q     <= fall_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         bad_q      <= bad_d;
         to_cnt_q   <= to_cnt_d;
         perr_q     <= perr_d;
         ovf_q      <= ovf_d;
         ferr_q     <= ferr_d;
      end
   end

`ifdef PS2_FIFO_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic unused_c;

   assign unused_c = ^data_in[28:0];
   assign irq_en   = irq_en_q;

   always_comb begin
      irq_en_d = irq_en_q;
      if (ctrl_wr_c) irq_en_d = data_in[CTRL_IRQ_EN_BIT];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) irq_en_q <= 1'b0;
      else          irq_en_q <= irq_en_d;
   end
`else
   logic unused_c;

   assign unused_c = ^data_in[29:0];
   assign irq_en   = 1'b0;
`endif

   ps2_scancode_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push_c),
      .pop     (pop_c),
      .flush   (flush_c),
      .wr_data (shift_q),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Read mux; the count field is 8 bits wide, so a 256-deep full FIFO wraps to 0
   always_comb begin
      status_c                                   = '0;
      status_c[STAT_NOT_EMPTY_BIT]               = ~fifo_empty;
      status_c[STAT_PARITY_ERR_BIT]              = perr_q;
      status_c[STAT_OVERFLOW_BIT]                = ovf_q;
      status_c[STAT_FRAME_ERR_BIT]               = ferr_q;
      status_c[STAT_IRQ_EN_BIT]                  = irq_en;
      status_c[STAT_COUNT_LSB +: STAT_COUNT_W]   = STAT_COUNT_W'(fifo_count);

      data_out = '0;
      if (status_cs) data_out = status_c;
      else if (scancode_cs && !fifo_empty) data_out[SCAN_LSB +: BYTE_W] = fifo_rd_data;

      data_out_valid = read & (status_cs | scancode_cs);
      irq            = irq_en & (~fifo_empty | perr_q | ovf_q | ferr_q);
   end

endmodule

// File: tb/tb_ps2_fifo_interface.sv
// Directed plus randomized bench for ps2_fifo_interface against a queue-based model.
// Honours PS2_FIFO_IRQ_EN when compiled with it.
module tb_ps2_fifo_interface;

   localparam int unsigned DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        read, write, status_cs, scancode_cs;
   logic [31:0] data_in;
   wire  [31:0] data_out;
   wire         data_out_valid, irq;
   logic        ps2_clk_drv, ps2_dat_drv;
   wire         ps2_clock, ps2_data;

   assign ps2_clock = ps2_clk_drv;
   assign ps2_data  = ps2_dat_drv;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_q[$];
   logic       m_perr, m_ovf, m_ferr, m_irq_en;

   always #5 clock = ~clock;

   ps2_fifo_interface #(
      .FIFO_DEPTH     (DEPTH),
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .read           (read),
      .write          (write),
      .status_cs      (status_cs),
      .scancode_cs    (scancode_cs),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .irq            (irq),
      .ps2_clock      (ps2_clock),
      .ps2_data       (ps2_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s      = '0;
      s[31]  = (m_q.size() != 0);
      s[30]  = m_perr;
      s[29]  = m_ovf;
      s[28]  = m_ferr;
`ifdef PS2_FIFO_IRQ_EN
      s[27]  = m_irq_en;
`endif
      s[23:16] = 8'(m_q.size());
      return s;
   endfunction

   function automatic logic m_irq();
`ifdef PS2_FIFO_IRQ_EN
      return m_irq_en & ((m_q.size() != 0) | m_perr | m_ovf | m_ferr);
`else
      return 1'b0;
`endif
   endfunction

   task automatic m_frame(input logic [7:0] b, input logic par_ok, input logic stop_v);
      if (!par_ok) m_perr = 1'b1;
      if (!stop_v) m_ferr = 1'b1;
      if (par_ok && stop_v) begin
         if (m_q.size() == DEPTH) m_ovf = 1'b1;
         else m_q.push_back(b);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_perr = 0; m_ovf = 0; m_ferr = 0; m_irq_en = 0;
   endtask

   // ---------------- bus and line drivers ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic bus_read(input logic st, output logic [31:0] d, output logic v);
      @(posedge clock); #1;
      read = 1'b1; status_cs = st; scancode_cs = ~st;
      @(negedge clock);
      d = data_out; v = data_out_valid;
      @(posedge clock); #1;
      read = 1'b0; status_cs = 1'b0; scancode_cs = 1'b0;
   endtask

   task automatic ctrl_write(input logic [31:0] v);
      @(posedge clock); #1;
      write = 1'b1; status_cs = 1'b1; data_in = v;
      @(posedge clock); #1;
      write = 1'b0; status_cs = 1'b0; data_in = '0;
      if (v[31]) m_q.delete();
      if (v[30]) begin m_perr = 0; m_ovf = 0; m_ferr = 0; end
`ifdef PS2_FIFO_IRQ_EN
      m_irq_en = v[29];
`endif
   endtask

   task automatic check_status(input string tag);
      logic [31:0] d;
      logic        v;
      bus_read(1'b1, d, v);
      check(tag, d, m_status());
      check({tag, "_valid"}, 32'(v), 32'd1);
      check({tag, "_irq"}, 32'(irq), 32'(m_irq()));
   endtask

   task automatic check_scan(input string tag);
      logic [31:0] d, exp;
      logic        v;
      exp = '0;
      if (m_q.size() != 0) exp = {m_q.pop_front(), 24'h0};
      bus_read(1'b0, d, v);
      check(tag, d, exp);
      check({tag, "_valid"}, 32'(v), 32'd1);
   endtask

   task automatic ps2_bit(input logic v);
      ps2_dat_drv = v;
      wait_clk(20);
      ps2_clk_drv = 1'b0;
      wait_clk(20);
      ps2_clk_drv = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_v);
      logic par;
      par = ~(^b);
      if (!par_ok) par = ~par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      ps2_bit(stop_v);
      ps2_dat_drv = 1'b1;
      wait_clk(30);
      m_frame(b, par_ok, stop_v);
   endtask

   // Watchdog so the run always ends
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, rv;
      logic        v;
      logic [7:0]  rb;
      logic        rp, rs;
      int          nr;

      reset_n = 1'b0; read = 0; write = 0; status_cs = 0; scancode_cs = 0;
      data_in = '0; ps2_clk_drv = 1'b1; ps2_dat_drv = 1'b1;
      m_reset();

      // Reset state
      @(negedge clock);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_valid_idle", 32'(data_out_valid), 32'd0);
      check("rst_nosel", data_out, 32'd0);
      status_cs = 1'b1;
      #1 check("rst_status", data_out, 32'd0);
      status_cs = 1'b0; scancode_cs = 1'b1;
      #1 check("rst_scan", data_out, 32'd0);
      scancode_cs = 1'b0;
      wait_clk(2);
      reset_n = 1'b1;
      wait_clk(2);
      check_status("post_rst_status");

      // Single frame then read back
      send_frame(8'h1C, 1'b1, 1'b1);
      check_scan("frame_1c");
      check_status("after_1c_status");
      check("after_1c_const", m_status(), 32'h0);

      // Overfill by one
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b1);
      bus_read(1'b1, d, v);
      check("nine_status", d, 32'hA008_0000);
      for (int i = 0; i < 8; i++) check_scan("nine_read");
      check_scan("empty_read");
      ctrl_write(32'h4000_0000);
      check_status("ovf_cleared");

      // Parity error
      send_frame(8'h5A, 1'b0, 1'b1);
      bus_read(1'b1, d, v);
      check("parity_status", d, 32'h4000_0000);
      ctrl_write(32'h4000_0000);
      bus_read(1'b1, d, v);
      check("parity_cleared", d, 32'h0);

      // Short glitch on the clock line must not start a frame
      ps2_dat_drv = 1'b0; ps2_clk_drv = 1'b0;
      wait_clk(7);
      ps2_clk_drv = 1'b1; ps2_dat_drv = 1'b1;
      wait_clk(150);
      check_status("glitch_status");
      send_frame(8'hA5, 1'b1, 1'b1);
      check_scan("after_glitch");

      // Partial frame abandoned: timeout raises frame_err
      ps2_bit(1'b0);
      ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      ps2_dat_drv = 1'b0;
      wait_clk(20);
      ps2_clk_drv = 1'b0;
      wait_clk(10);
      ps2_clk_drv = 1'b1; ps2_dat_drv = 1'b1;
      wait_clk(80);
      check_status("timeout_pending");
      wait_clk(33);
      m_ferr = 1'b1;
      check_status("timeout_ferr");
      send_frame(8'h29, 1'b1, 1'b1);
      check_scan("after_timeout");
      bus_read(1'b1, d, v);
      check("after_timeout_status", d, 32'h1000_0000);
      ctrl_write(32'h4000_0000);

      // Bad stop bit
      send_frame(8'h33, 1'b1, 1'b0);
      check_status("stop_err");
      ctrl_write(32'h4000_0000);

      // Interrupt enable
      ctrl_write(32'h2000_0000);
      check_status("irq_en_status");
      send_frame(8'h76, 1'b1, 1'b1);
`ifdef PS2_FIFO_IRQ_EN
      check("irq_high", 32'(irq), 32'd1);
`else
      check("irq_tied", 32'(irq), 32'd0);
`endif
      check_scan("irq_read");
      check("irq_low", 32'(irq), 32'd0);

      // Flush
      for (int i = 0; i < 3; i++) send_frame(8'(8'hC0 + i), 1'b1, 1'b1);
      check_status("pre_flush");
      ctrl_write(32'h8000_0000);
      check_status("post_flush");
      check_scan("flush_empty_read");

      // Reset in the middle of a frame
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
      reset_n = 1'b0;
      m_reset();
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(150);
      check_status("midframe_reset");
      send_frame(8'h29, 1'b1, 1'b1);
      check_scan("after_midframe_reset");

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         rb = 8'($urandom);
         rp = ($urandom_range(0, 5) != 0);
         rs = ($urandom_range(0, 7) != 0);
         send_frame(rb, rp, rs);
         nr = $urandom_range(0, 2);
         for (int k = 0; k < nr; k++) check_scan("rand_scan");
         check_status("rand_status");
         if (i % 8 == 7) begin
            rv = $urandom;
            ctrl_write(rv);
            check_status("rand_ctrl");
         end
      end
      while (m_q.size() != 0) check_scan("drain_scan");
      check_status("final_status");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_fifo_interface.md
PS2_FIFO_INTERFACE -- requirements
Module: ps2_fifo_interface

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: scancode FIFO entries; power of two, range 2..256.
REQ-002 Parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a ps2_clock level change.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: clocks without a falling edge before an in-progress frame is aborted.
REQ-004 clock  input  1  system clock; the block SHALL use this one clock only.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 read  input  1  bus read strobe.
REQ-007 write  input  1  bus write strobe.
REQ-008 status_cs  input  1  selects the status/control register.
REQ-009 scancode_cs  input  1  selects the scancode FIFO head.
REQ-010 data_in  input  32  write data; only bits 31:29 are used.
REQ-011 data_out  output  32  read data, combinational from the selects.
REQ-012 data_out_valid  output  1  high iff read && (status_cs || scancode_cs).
REQ-013 irq  output  1  interrupt request, level.
REQ-014 ps2_clock, ps2_data  inout  1 each  PS/2 lines; receive-only, never driven (always high-Z).

Function
REQ-015 Input conditioning: both lines SHALL pass a 2-flop synchroniser; filtered clock changes only after FILTER_LEN equal samples; a 1->0 filtered transition is one falling-edge pulse.
REQ-016 Receiver FSM states IDLE, DATA, PARITY, STOP, all sampling ps2_data on falling edges.
REQ-017 IDLE: data 0 -> DATA with bit count 0; data 1 -> stay IDLE, no flag.
REQ-018 DATA: 8 bits shifted LSB first; after the 8th -> PARITY.
REQ-019 PARITY: the 8 data bits plus the parity bit SHALL have odd parity; on mismatch set sticky parity_err and mark the byte for discard; -> STOP.
REQ-020 STOP: data 1 and no parity error -> push the byte; data 0 -> set sticky frame_err and discard; always -> IDLE.
REQ-021 Timeout: in any state other than IDLE, TIMEOUT_CYCLES clocks with no falling edge -> IDLE, set frame_err, discard the partial byte.
REQ-022 A pushed byte SHALL be readable on the cycle after the stop-bit edge.
REQ-023 Push when full without a same-cycle pop: drop the new byte, set sticky overflow; existing contents unchanged.
REQ-024 Push and pop in the same cycle when full: both succeed; count unchanged.
REQ-025 Status read data_out: [31] FIFO not empty, [30] parity_err, [29] overflow, [28] frame_err, [27] irq_en, [23:16] count zero-extended, all other bits 0.
REQ-026 Scancode read: data_out[31:24] = head byte, other bits 0; read && scancode_cs pops one entry when not empty; an empty read returns 0 and does not pop.
REQ-027 Control write, write && status_cs: data_in[31]=1 flushes the FIFO; data_in[30]=1 clears all three sticky flags.
REQ-028 Flush in the same cycle as a push: flush wins and the byte is dropped.
REQ-029 Error clear in the same cycle as a new error: the new error wins and its flag is set.
REQ-030 Neither select asserted: data_out = 0.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.

Reset
REQ-032 Asserting reset_n low SHALL, immediately: FSM -> IDLE; FIFO empty; sticky flags 0; irq_en 0; irq 0; filter/synchroniser state high (idle bus).
REQ-033 A frame in progress at reset is discarded without setting any flag.

Configuration
REQ-034 With macro PS2_FIFO_IRQ_EN defined: data_in[29] on a control write sets irq_en; irq = irq_en && (FIFO not empty || any sticky flag).
REQ-035 With PS2_FIFO_IRQ_EN undefined: irq tied 0, status bit 27 reads 0, data_in[29] ignored.

Structure
REQ-036 Shared package ps2_pkg SHALL hold the status bit positions, the control bit positions and the receiver FSM state encoding.
REQ-037 The FIFO SHALL be a sub-module ps2_scancode_fifo (parameter DEPTH; push, pop, flush, full, empty, count).

Verification
REQ-038 Frame 0x1C with correct parity, then scancode read -> data_out = 0x1C000000; status then reads 0x00000000.
REQ-039 Nine frames 0x01..0x09 with FIFO_DEPTH 8, no reads -> status = 0xA0080000; eight reads return 0x01..0x08.
REQ-040 Frame 0x5A with a wrong parity bit -> FIFO stays empty; status = 0x40000000; control write 0x40000000 -> status = 0.
REQ-041 Stop 10 clocks after the 4th data bit with TIMEOUT_CYCLES=100 -> frame_err set 100 clocks after the last edge; the next valid frame 0x29 is received normally.
REQ-042 Glitch of FILTER_LEN-1 clocks low on ps2_clock -> no edge, FSM stays IDLE.
REQ-043 With PS2_FIFO_IRQ_EN: control write 0x20000000, then frame 0x76 -> irq=1; scancode read -> irq=0.
